// File: rtl/regfile_pkg.sv
// Shared definitions for the arbitrated register file: default geometry,
// requester identity and access kind, plus the round-robin pick helper.
package regfile_pkg;

    localparam int unsigned RF_WIDTH  = 8;
    localparam int unsigned RF_DEPTH  = 4;
    localparam int unsigned CONF_W    = 8;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } acc_kind_e;

    // On a tie the requester that did not win most recently gets the slot.
    function automatic req_id_e rr_pick(input logic e0, input logic e1, input req_id_e last);
        if (e0 && e1) begin
            return (last == REQ1) ? REQ0 : REQ1;
        end
        return e0 ? REQ0 : REQ1;
    endfunction

endpackage

// File: rtl/regfile_core.sv
// Register storage: one synchronous write port, one combinational read port,
// asynchronous clear. Out-of-range addresses write nothing and read as zero.
module regfile_core
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = RF_WIDTH,
    parameter int unsigned DEPTH = RF_DEPTH,
    parameter int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             we,
    input  logic [IW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mem_q <= '{default: '0};
        end else if (we && (32'(waddr) < DEPTH)) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (32'(raddr) < DEPTH) begin
            rdata = mem_q[raddr];
        end
    end

endmodule

// File: rtl/regfile_arb.sv
// Two-requester round-robin arbiter in front of regfile_core; one access per edge.
// Optional saturating tie counter on output conflict_cnt when RFARB_CONFLICT_CNT_EN is defined.
module regfile_arb
    import regfile_pkg::*;
#(
    parameter  int unsigned WIDTH = RF_WIDTH,
    parameter  int unsigned DEPTH = RF_DEPTH,
    localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             req_0,
    input  logic             req_1,
    input  logic             we_0,
    input  logic             we_1,
    input  logic [IW-1:0]    idx_0,
    input  logic [IW-1:0]    idx_1,
    input  logic [WIDTH-1:0] wdata_0,
    input  logic [WIDTH-1:0] wdata_1,
    output logic             gnt_0,
    output logic             gnt_1,
    output logic             rvalid_0,
    output logic             rvalid_1,
    output logic [WIDTH-1:0] rdata_0,
    output logic [WIDTH-1:0] rdata_1
`ifdef RFARB_CONFLICT_CNT_EN
    ,
    output logic [CONF_W-1:0] conflict_cnt
`endif
);

    logic [1:0]       gnt_q;
    logic [1:0]       rvalid_q;
    logic [WIDTH-1:0] rdata_q [2];
    req_id_e          last_gnt_q;

    logic             elig0, elig1, any_elig;
    req_id_e          sel;
    acc_kind_e        sel_kind;
    logic [IW-1:0]    sel_idx;
    logic [WIDTH-1:0] sel_wdata;
    logic [WIDTH-1:0] core_rdata;
    logic             core_we;

    // A requester still showing its grant pulse is not eligible this edge.
    always_comb begin
        elig0    = req_0 & ~gnt_q[0];
        elig1    = req_1 & ~gnt_q[1];
        any_elig = elig0 | elig1;
        sel      = rr_pick(elig0, elig1, last_gnt_q);
        if (sel == REQ0) begin
            sel_kind  = acc_kind_e'(we_0);
            sel_idx   = idx_0;
            sel_wdata = wdata_0;
        end else begin
            sel_kind  = acc_kind_e'(we_1);
            sel_idx   = idx_1;
            sel_wdata = wdata_1;
        end
        core_we = any_elig && (sel_kind == WR);
    end

    regfile_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_core (
        .clk   (clk),
        .clr_n (clr_n),
        .we    (core_we),
        .waddr (sel_idx),
        .wdata (sel_wdata),
        .raddr (sel_idx),
        .rdata (core_rdata)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            gnt_q      <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '{default: '0};
            last_gnt_q <= REQ1;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            if (any_elig) begin
                gnt_q[sel] <= 1'b1;
                last_gnt_q <= sel;
                if (sel_kind == RD) begin
                    rvalid_q[sel] <= 1'b1;
                    rdata_q[sel]  <= core_rdata;
                end
            end
        end
    end

    assign gnt_0    = gnt_q[0];
    assign gnt_1    = gnt_q[1];
    assign rvalid_0 = rvalid_q[0];
    assign rvalid_1 = rvalid_q[1];
    assign rdata_0  = rdata_q[0];
    assign rdata_1  = rdata_q[1];

`ifdef RFARB_CONFLICT_CNT_EN
    logic              both_elig;
    logic [CONF_W-1:0] conf_q;

    assign both_elig = elig0 & elig1;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            conf_q <= '0;
        end else if (both_elig && (conf_q != '1)) begin
            conf_q <= conf_q + 1'b1;
        end
    end

    assign conflict_cnt = conf_q;
`endif

endmodule

// File: tb/tb_regfile_arb.sv
// Bench for regfile_arb: directed vector table, hand sequences for ties, holding
// requests and async clear, then random traffic against a behavioural model.
module tb_regfile_arb;
    import regfile_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          clr_n;
    logic          req_0, req_1, we_0, we_1;
    logic [IW-1:0] idx_0, idx_1;
    logic [W-1:0]  wdata_0, wdata_1;
    logic          gnt_0, gnt_1, rvalid_0, rvalid_1;
    logic [W-1:0]  rdata_0, rdata_1;
`ifdef RFARB_CONFLICT_CNT_EN
    logic [7:0]    conflict_cnt;
`endif

    always #5 clk = ~clk;

    regfile_arb #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .req_0    (req_0),
        .req_1    (req_1),
        .we_0     (we_0),
        .we_1     (we_1),
        .idx_0    (idx_0),
        .idx_1    (idx_1),
        .wdata_0  (wdata_0),
        .wdata_1  (wdata_1),
        .gnt_0    (gnt_0),
        .gnt_1    (gnt_1),
        .rvalid_0 (rvalid_0),
        .rvalid_1 (rvalid_1),
        .rdata_0  (rdata_0),
        .rdata_1  (rdata_1)
`ifdef RFARB_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Behavioural model: storage array, most-recent winner, pending pulses.
    logic [W-1:0] m_mem [D];
    int           m_last;
    bit           m_gnt [2];
    bit           m_rv  [2];
    logic [W-1:0] m_rd  [2];
    int           m_conf;

    task automatic model_reset();
        for (int unsigned k = 0; k < D; k++) m_mem[k] = '0;
        m_last = 1;
        m_gnt[0] = 1'b0; m_gnt[1] = 1'b0;
        m_rv[0]  = 1'b0; m_rv[1]  = 1'b0;
        m_rd[0]  = '0;   m_rd[1]  = '0;
        m_conf = 0;
    endtask

    task automatic model_edge();
        bit e0, e1, wk;
        int w, ix;
        logic [W-1:0] wd;
        e0 = req_0 && !m_gnt[0];
        e1 = req_1 && !m_gnt[1];
        w  = -1;
        if (e0 && e1) begin
            w = 1 - m_last;
            if (m_conf < 255) m_conf++;
        end else if (e0) begin
            w = 0;
        end else if (e1) begin
            w = 1;
        end
        m_gnt[0] = 1'b0; m_gnt[1] = 1'b0;
        m_rv[0]  = 1'b0; m_rv[1]  = 1'b0;
        if (w >= 0) begin
            wk = (w == 0) ? we_0 : we_1;
            ix = (w == 0) ? int'(idx_0) : int'(idx_1);
            wd = (w == 0) ? wdata_0 : wdata_1;
            m_gnt[w] = 1'b1;
            m_last   = w;
            if (wk) begin
                if (ix < int'(D)) m_mem[ix] = wd;
            end else begin
                m_rv[w] = 1'b1;
                m_rd[w] = (ix < int'(D)) ? m_mem[ix] : '0;
            end
        end
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [IW-1:0] i0, input logic [W-1:0] d0,
                         input bit r1, input bit w1, input logic [IW-1:0] i1, input logic [W-1:0] d1);
        req_0 = r0; we_0 = w0; idx_0 = i0; wdata_0 = d0;
        req_1 = r1; we_1 = w1; idx_1 = i1; wdata_1 = d1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check(input string nm, input bit g0, input bit g1, input bit v0, input bit v1,
                         input logic [W-1:0] q0, input logic [W-1:0] q1);
        n_vec++;
        if (gnt_0 !== g0 || gnt_1 !== g1 || rvalid_0 !== v0 || rvalid_1 !== v1 ||
            rdata_0 !== q0 || rdata_1 !== q1) begin
            n_err++;
            $display("FAIL %s: got gnt=%b%b rvalid=%b%b rdata0=%h rdata1=%h, expected gnt=%b%b rvalid=%b%b rdata0=%h rdata1=%h",
                     nm, gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1, g0, g1, v0, v1, q0, q1);
        end
    endtask

    task automatic check_model(input string nm);
        check(nm, m_gnt[0], m_gnt[1], m_rv[0], m_rv[1], m_rd[0], m_rd[1]);
`ifdef RFARB_CONFLICT_CNT_EN
        n_vec++;
        if (int'(conflict_cnt) != m_conf) begin
            n_err++;
            $display("FAIL %s_conflict_cnt: got %0d, expected %0d", nm, conflict_cnt, m_conf);
        end
`endif
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", nm, got, exp);
        end
    endtask

    typedef struct {
        bit             r0, w0;
        logic [IW-1:0]  i0;
        logic [W-1:0]   d0;
        bit             r1, w1;
        logic [IW-1:0]  i1;
        logic [W-1:0]   d1;
        bit             g0, g1, v0, v1;
        logic [W-1:0]   q0, q1;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit prev_g0;
        bit exp_g0 [6];
        bit exp_g1 [6];
        bit tie_r  [6];

        //             r0    w0    i0    d0      r1    w1    i1    d1      g0    g1    v0    v1    q0     q1
        tbl[0]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 2'd2, 8'hA5, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[3]  = '{1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h00};
        tbl[4]  = '{1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 8'hA5};
        tbl[5]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5};
        tbl[6]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 2'd3, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5};
        tbl[7]  = '{1'b1, 1'b0, 2'd3, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 8'hA5};
        tbl[8]  = '{1'b1, 1'b1, 2'd0, 8'h11, 1'b1, 1'b1, 2'd1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 8'hA5};
        tbl[9]  = '{1'b1, 1'b0, 2'd1, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h77, 8'hA5};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 8'hA5};
        tbl[11] = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 8'h77};
        tbl[12] = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd3, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h77};
        tbl[13] = '{1'b1, 1'b0, 2'd3, 8'h00, 1'b1, 1'b1, 2'd0, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h77};
        tbl[14] = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hEE, 8'h77};

        clr_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        clr_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].r0, tbl[i].w0, tbl[i].i0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].i1, tbl[i].d1);
            tick();
            check($sformatf("table_%0d", i), tbl[i].g0, tbl[i].g1, tbl[i].v0, tbl[i].v1, tbl[i].q0, tbl[i].q1);
        end

        // Ties from a fresh reset: 0 first, 1 when both are held, then alternating.
        clr_n = 1'b0;
        idle();
        #1;
        model_reset();
        @(negedge clk);
        clr_n = 1'b1;
        tie_r  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_g0 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_g1 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(tie_r[i], 1'b0, 2'd1, 8'h00, tie_r[i], 1'b0, 2'd2, 8'h00);
            tick();
            chk1($sformatf("tie_gnt0_%0d", i), gnt_0, exp_g0[i]);
            chk1($sformatf("tie_gnt1_%0d", i), gnt_1, exp_g1[i]);
        end

        // req_0 held high: grant on alternate cycles only.
        idle();
        tick();
        prev_g0 = 1'b0;
        drive(1'b1, 1'b0, 2'd2, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1($sformatf("hold_gnt0_%0d", i), gnt_0, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk1($sformatf("hold_no_b2b_%0d", i), prev_g0 & gnt_0, 1'b0);
            prev_g0 = gnt_0;
        end

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
            tick();
            check_model($sformatf("rand_%0d", i));
        end

        for (int i = 0; i < 4; i++) begin
            idle();
            tick();
            drive(1'b1, 1'b1, 2'(i), 8'(8'h51 + 8'(i)), 1'b0, 1'b0, 2'd0, 8'h00);
            tick();
            check_model($sformatf("fill_%0d", i));
        end
        idle();
        tick();

        // Clear asserted while a read grant pulse is showing.
        drive(1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
        @(posedge clk);
        model_edge();
        #1;
        chk1("pre_clr_rvalid0", rvalid_0, 1'b1);
        #1;
        clr_n = 1'b0;
        #1;
        model_reset();
        check_model("async_clr");
        idle();
        @(negedge clk);
        clr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'(i), 8'h00);
            tick();
            check("post_clr_read", 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
            idle();
            tick();
        end
        drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00);
        tick();
        chk1("post_clr_tie_gnt0", gnt_0, 1'b1);
        chk1("post_clr_tie_gnt1", gnt_1, 1'b0);
        idle();
        tick();

`ifdef RFARB_CONFLICT_CNT_EN
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd1, 8'h00);
            tick();
            idle();
            tick();
        end
        check_model("conflict_sat");
        n_vec++;
        if (conflict_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL conflict_cnt_255: got %0d, expected 255", conflict_cnt);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
